ibex_dummy_reseed_ctrl: RTL and testbench
=========================================

IBEX_DUMMY_RESEED_CTRL -- requirements
Module: ibex_dummy_reseed_ctrl

Interface
REQ-001 Parameter ReseedPeriodW, default 16, width of the reseed period timer.
REQ-002 Parameter EntropyW, default 16, entropy beat width; SHALL divide 32 (legal values: 8, 16, 32).
REQ-003 clk_i  input  1  sole clock; all state sampled on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 reseed_en_i  input  1  enable for periodic and triggered entropy reseeding.
REQ-006 reseed_period_i  input  ReseedPeriodW  cycles between reseeds; 0 disables the periodic timer.
REQ-007 reseed_trigger_i  input  1  single-cycle request for an immediate reseed.
REQ-008 csr_seed_en_i  input  1  CSR seed write strobe.
REQ-009 csr_seed_i  input  32  CSR seed value.
REQ-010 entropy_req_o  output  1  entropy request.
REQ-011 entropy_ack_i  input  1  entropy beat valid.
REQ-012 entropy_data_i  input  EntropyW  entropy beat.
REQ-013 dummy_instr_seed_en_o  output  1  one-cycle seed load strobe to the dummy-instruction generator.
REQ-014 dummy_instr_seed_o  output  32  seed value; qualified by dummy_instr_seed_en_o.
REQ-015 reseed_busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, APPLY and DRAIN.
REQ-017 Timer: in IDLE, with reseed_en_i=1 and period!=0, increment each cycle; on reaching reseed_period_i-1, clear and go to FETCH; period is sampled on each compare, not latched.
REQ-018 In IDLE, reseed_trigger_i=1 with reseed_en_i=1 SHALL go to FETCH next cycle and clear the timer.
REQ-019 In FETCH, entropy_req_o=1; each cycle with entropy_ack_i=1, the beat SHALL shift into a 32-bit accumulator, LSB beat first, and the beat counter increments.
REQ-020 After the 32/EntropyW-th acked beat, go to APPLY; with EntropyW=16 the minimum FETCH-to-APPLY latency is 2 cycles.
REQ-021 entropy_req_o SHALL stay high from FETCH entry until an ack; it SHALL never drop without an ack.
REQ-022 In APPLY, drive dummy_instr_seed_en_o=1 and dummy_instr_seed_o=accumulator for exactly one cycle, then return to IDLE.
REQ-023 A CSR write (csr_seed_en_i=1) SHALL pass through combinationally in any state: seed_en_o=1 and seed_o=csr_seed_i in the same cycle.
REQ-024 If a CSR write and APPLY coincide, the CSR seed SHALL win; the FSM stays in APPLY and emits the entropy seed on the next cycle without a CSR write.
REQ-025 If reseed_en_i falls in FETCH, go to DRAIN; DRAIN SHALL hold entropy_req_o=1 until one ack, discard the accumulator, then go to IDLE; no seed SHALL be emitted.
REQ-026 If reseed_en_i falls in APPLY, the pending seed SHALL still be emitted.
REQ-027 reseed_trigger_i SHALL be ignored outside IDLE; a timer expiry outside IDLE cannot occur because the timer only runs in IDLE.
REQ-028 Timer and beat counters SHALL wrap modulo their width; no overflow flag.
REQ-029 dummy_instr_seed_o SHALL be 0 whenever dummy_instr_seed_en_o=0.

Reset
REQ-030 On rst_ni low, the FSM SHALL go to IDLE immediately, and the timer, beat counter and accumulator SHALL go to 0.
REQ-031 On rst_ni low, entropy_req_o, dummy_instr_seed_en_o and reseed_busy_o SHALL be 0 and dummy_instr_seed_o SHALL be 0.
REQ-032 A reset during FETCH SHALL abandon the handshake; the entropy source tolerates a req drop only under reset.

Structure
REQ-033 The FSM state enum (reseed_state_e) and the constant for default period width SHALL live in ibex_pkg.
REQ-034 The design SHALL be one module with no sub-modules; the accumulator is a shift register inside it.
REQ-035 Its outputs SHALL connect directly to the dummy_instr_seed_en_i and dummy_instr_seed_i inputs of ibex_dummy_instr.

Verification
REQ-036 Periodic reseed (period=4, EntropyW=16): ack beats 0x1234 then 0xABCD -> seed_en one cycle with seed 0xABCD1234; second FETCH starts 4 cycles after return to IDLE.
REQ-037 Held request: hold ack low for 10 cycles -> entropy_req_o stays 1 throughout; seed is emitted 1 cycle after the second ack.
REQ-038 Collision: CSR write of 0xDEADBEEF in the APPLY cycle -> 0xDEADBEEF emitted that cycle, entropy seed emitted the next cycle, 2 strobes total.
REQ-039 Disable mid-fetch: drop reseed_en_i after the first beat -> DRAIN, req held until the next ack, no seed_en, then IDLE with busy=0.
REQ-040 Reset mid-fetch: assert rst_ni low with req=1 -> req, busy and seed_en are 0 immediately; after release, FETCH resumes only on trigger or timer expiry.
REQ-041 Period=0 with trigger: no automatic FETCH over 1000 cycles; a single trigger produces exactly one reseed.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types for the dummy-instruction reseed controller.
// Holds the reseed FSM state encoding and the default timer width.
// No logic; imported by the controller.
package ibex_pkg;

  // Default width of the periodic reseed timer.
  localparam int unsigned ReseedPeriodWDefault = 16;

  typedef enum logic [1:0] {
    RESEED_IDLE  = 2'd0,
    RESEED_FETCH = 2'd1,
    RESEED_APPLY = 2'd2,
    RESEED_DRAIN = 2'd3
  } reseed_state_e;

endpackage

// File: rtl/ibex_dummy_reseed_ctrl.sv
// Reseeds the dummy-instruction generator from entropy beats, periodically or on trigger.
// Latency: 32/EntropyW acked beats in FETCH, then one APPLY cycle emits the seed.
// Backpressure: entropy_req_o is held until acked; CSR writes bypass and pre-empt APPLY.
module ibex_dummy_reseed_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned ReseedPeriodW = ReseedPeriodWDefault,
  parameter int unsigned EntropyW      = 16  // must divide 32: 8, 16 or 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     reseed_en_i,
  input  logic [ReseedPeriodW-1:0] reseed_period_i,
  input  logic                     reseed_trigger_i,
  input  logic                     csr_seed_en_i,
  input  logic [31:0]              csr_seed_i,
  output logic                     entropy_req_o,
  input  logic                     entropy_ack_i,
  input  logic [EntropyW-1:0]      entropy_data_i,
  output logic                     dummy_instr_seed_en_o,
  output logic [31:0]              dummy_instr_seed_o,
  output logic                     reseed_busy_o
);

  localparam int unsigned NumBeats = 32 / EntropyW;
  localparam int unsigned BeatCntW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatCntW-1:0]      LastBeat  = BeatCntW'(NumBeats - 1);
  localparam logic [ReseedPeriodW-1:0] PeriodOne = ReseedPeriodW'(1);

  reseed_state_e            state_q, state_d;
  logic [ReseedPeriodW-1:0] timer_q, timer_d;
  logic [BeatCntW-1:0]      beat_q, beat_d;
  logic [31:0]              acc_q, acc_d;
  logic [31:0]              acc_shift;

  // New beats enter at the top so the first beat ends up in the LSBs.
  if (EntropyW == 32) begin : g_acc_full
    assign acc_shift = entropy_data_i;
  end else begin : g_acc_part
    assign acc_shift = {entropy_data_i, acc_q[31:EntropyW]};
  end

  // Next-state, counters and outputs; CSR writes override the seed port in any state.
  always_comb begin
    state_d               = state_q;
    timer_d               = timer_q;
    beat_d                = beat_q;
    acc_d                 = acc_q;
    entropy_req_o         = 1'b0;
    dummy_instr_seed_en_o = 1'b0;
    dummy_instr_seed_o    = 32'h0;

    unique case (state_q)
      RESEED_IDLE: begin
        if (reseed_en_i) begin
          if (reseed_trigger_i) begin
            timer_d = '0;
            state_d = RESEED_FETCH;
          end else if (reseed_period_i != '0) begin
            // Period is compared live so a reprogrammed value takes effect at once.
            if (timer_q == reseed_period_i - PeriodOne) begin
              timer_d = '0;
              state_d = RESEED_FETCH;
            end else begin
              timer_d = timer_q + PeriodOne;
            end
          end
        end
      end

      RESEED_FETCH: begin
        entropy_req_o = 1'b1;
        if (!reseed_en_i) begin
          // An ack in this very cycle already closes the handshake, so there
          // is nothing left to drain; otherwise wait out the pending request.
          if (entropy_ack_i) begin
            acc_d   = '0;
            beat_d  = '0;
            state_d = RESEED_IDLE;
          end else begin
            state_d = RESEED_DRAIN;
          end
        end else if (entropy_ack_i) begin
          acc_d = acc_shift;
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = RESEED_APPLY;
          end else begin
            beat_d = beat_q + BeatCntW'(1);
          end
        end
      end

      RESEED_APPLY: begin
        dummy_instr_seed_en_o = 1'b1;
        // A concurrent CSR write owns the port this cycle; retry next cycle.
        if (!csr_seed_en_i) begin
          dummy_instr_seed_o = acc_q;
          state_d            = RESEED_IDLE;
        end
      end

      RESEED_DRAIN: begin
        entropy_req_o = 1'b1;
        if (entropy_ack_i) begin
          acc_d   = '0;
          beat_d  = '0;
          state_d = RESEED_IDLE;
        end
      end

      default: state_d = RESEED_IDLE;
    endcase

    // CSR seed passes straight through; suppressed while held in reset.
    if (csr_seed_en_i && rst_ni) begin
      dummy_instr_seed_en_o = 1'b1;
      dummy_instr_seed_o    = csr_seed_i;
    end
  end

  assign reseed_busy_o = (state_q != RESEED_IDLE);

  // State, timer, beat counter and accumulator registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESEED_IDLE;
      timer_q <= '0;
      beat_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_ibex_dummy_reseed_ctrl.sv
// Bench for the reseed controller: directed scenarios plus randomized reseeds.
// Expected seeds are queued at stimulus time; a monitor pops them on each strobe.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ibex_dummy_reseed_ctrl;

  localparam int unsigned PW = 16;
  localparam int unsigned EW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [PW-1:0] period = '0;
  logic          trig = 1'b0;
  logic          csr_en = 1'b0;
  logic [31:0]   csr = 32'h0;
  logic          req;
  logic          ack = 1'b0;
  logic [EW-1:0] edata = '0;
  logic          seed_en;
  logic [31:0]   seed;
  logic          busy;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  logic [31:0] exp_q[$];

  ibex_dummy_reseed_ctrl #(.ReseedPeriodW(PW), .EntropyW(EW)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .reseed_en_i          (en),
    .reseed_period_i      (period),
    .reseed_trigger_i     (trig),
    .csr_seed_en_i        (csr_en),
    .csr_seed_i           (csr),
    .entropy_req_o        (req),
    .entropy_ack_i        (ack),
    .entropy_data_i       (edata),
    .dummy_instr_seed_en_o(seed_en),
    .dummy_instr_seed_o   (seed),
    .reseed_busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chkb(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  // Reference: a seed is the beats laid out LSB-first, EW bits each.
  function automatic logic [31:0] model_seed(input logic [EW-1:0] b0, input logic [EW-1:0] b1);
    return (32'(b1) << EW) | 32'(b0);
  endfunction

  // Scoreboard monitor: every strobe must match the oldest expected seed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (seed_en) begin
        strobes++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_seed: got 0x%08h with no seed expected at %0t", seed, $time);
        end else begin
          chk("seed_value", seed, exp_q.pop_front());
        end
      end else begin
        chk("seed_zero_when_idle", seed, 32'h0);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One-cycle trigger; returns in the first FETCH cycle.
  task automatic do_trigger();
    trig = 1'b1;
    nxt();
    trig = 1'b0;
  endtask

  // Counts IDLE cycles before req rises; returns in the second FETCH cycle.
  task automatic wait_fetch(output int n, input int limit);
    bit found = 1'b0;
    n = 0;
    for (int i = 0; i < limit; i++) begin
      smp();
      if (req) begin
        found = 1'b1;
        break;
      end
      chkb("busy_low_in_idle", busy, 1'b0);
      n++;
      nxt();
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: no entropy_req_o within %0d cycles", limit);
    end else begin
      nxt();
    end
  endtask

  // Delivers two beats with gap cycles before each; optional CSR writes in gaps.
  task automatic feed(input logic [EW-1:0] b0, input logic [EW-1:0] b1,
                      input int gap0, input int gap1, input bit rand_csr);
    for (int k = 0; k < 2; k++) begin
      for (int g = 0; g < ((k == 0) ? gap0 : gap1); g++) begin
        ack = 1'b0;
        if (rand_csr && ($urandom_range(0, 2) == 0)) begin
          csr_en = 1'b1;
          csr = $urandom;
          exp_q.push_back(csr);
        end
        smp();
        chkb("req_held_without_ack", req, 1'b1);
        nxt();
        csr_en = 1'b0;
      end
      ack = 1'b1;
      edata = (k == 0) ? b0 : b1;
      smp();
      chkb("req_at_ack", req, 1'b1);
      nxt();
      ack = 1'b0;
    end
  endtask

  // APPLY cycle (optionally colliding with a CSR write); returns in first IDLE cycle.
  task automatic finish_apply(input logic [31:0] eseed, input bit collide);
    if (collide) begin
      csr_en = 1'b1;
      csr = 32'hDEADBEEF;
      exp_q.push_back(32'hDEADBEEF);
    end
    exp_q.push_back(eseed);
    smp();
    chkb("apply_strobe", seed_en, 1'b1);
    chkb("apply_busy", busy, 1'b1);
    chkb("apply_req_low", req, 1'b0);
    nxt();
    csr_en = 1'b0;
    if (collide) begin
      smp();
      chkb("deferred_strobe", seed_en, 1'b1);
      nxt();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    int cnt;
    logic [EW-1:0] b0, b1;

    // Reset state, including a CSR strobe that must be suppressed.
    csr_en = 1'b1;
    csr = 32'h12345678;
    #3;
    chkb("rst_req", req, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_seed_en", seed_en, 1'b0);
    chk("rst_seed", seed, 32'h0);
    csr_en = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();

    // Periodic reseed with period 4.
    en = 1'b1;
    period = 16'd4;
    wait_fetch(n, 100);
    chk("first_period_wait", 32'(n), 32'd4);
    feed(16'h1234, 16'hABCD, 0, 0, 1'b0);
    finish_apply(32'hABCD1234, 1'b0);
    wait_fetch(n, 100);
    chk("second_period_wait", 32'(n), 32'd4);
    period = '0;
    feed(16'h5A5A, 16'h0F0F, 0, 0, 1'b0);
    finish_apply(model_seed(16'h5A5A, 16'h0F0F), 1'b0);

    // Held request: ack withheld for 10 cycles.
    do_trigger();
    feed(16'h1111, 16'h2222, 10, 0, 1'b0);
    finish_apply(model_seed(16'h1111, 16'h2222), 1'b0);

    // Collision of a CSR write with APPLY.
    s0 = strobes;
    do_trigger();
    feed(16'hC0DE, 16'hFACE, 0, 0, 1'b0);
    finish_apply(model_seed(16'hC0DE, 16'hFACE), 1'b1);
    smp();
    chk("collision_strobe_count", 32'(strobes - s0), 32'd2);
    nxt();

    // Disable mid-fetch: drain one ack, emit nothing.
    s0 = strobes;
    do_trigger();
    ack = 1'b1;
    edata = 16'h7777;
    nxt();
    ack = 1'b0;
    en = 1'b0;
    nxt();
    for (int i = 0; i < 3; i++) begin
      smp();
      chkb("drain_req", req, 1'b1);
      chkb("drain_busy", busy, 1'b1);
      nxt();
    end
    ack = 1'b1;
    smp();
    chkb("drain_req_at_ack", req, 1'b1);
    nxt();
    ack = 1'b0;
    smp();
    chkb("drain_done_busy", busy, 1'b0);
    chkb("drain_done_req", req, 1'b0);
    chk("drain_no_seed", 32'(strobes - s0), 32'd0);
    nxt();
    en = 1'b1;

    // Reset mid-fetch after one beat has been accepted.
    do_trigger();
    ack = 1'b1;
    edata = 16'h4444;
    nxt();
    ack = 1'b0;
    smp();
    chkb("pre_reset_req", req, 1'b1);
    nxt();
    rst_n = 1'b0;
    csr_en = 1'b1;
    #1;
    chkb("reset_req", req, 1'b0);
    chkb("reset_busy", busy, 1'b0);
    chkb("reset_seed_en", seed_en, 1'b0);
    csr_en = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (req) cnt++;
      nxt();
    end
    chk("no_fetch_after_reset", 32'(cnt), 32'd0);
    do_trigger();
    feed(16'h8001, 16'h1008, 0, 0, 1'b0);
    finish_apply(model_seed(16'h8001, 16'h1008), 1'b0);

    // Period 0: timer idle for 1000 cycles, then exactly one triggered reseed.
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      smp();
      if (req || busy) cnt++;
      nxt();
    end
    chk("period0_no_auto_fetch", 32'(cnt), 32'd0);
    s0 = strobes;
    do_trigger();
    feed(16'h0001, 16'h8000, 1, 2, 1'b0);
    finish_apply(model_seed(16'h0001, 16'h8000), 1'b0);
    for (int i = 0; i < 5; i++) nxt();
    chk("period0_single_reseed", 32'(strobes - s0), 32'd1);

    // Randomized mix of triggered/periodic reseeds, collisions and idle CSR writes.
    for (int it = 0; it < 30; it++) begin
      b0 = EW'($urandom);
      b1 = EW'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          do_trigger();
          feed(b0, b1, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
          finish_apply(model_seed(b0, b1), 1'($urandom_range(0, 1)));
        end
        1: begin
          int p;
          p = $urandom_range(1, 6);
          period = PW'(p);
          wait_fetch(n, 100);
          chk("rand_period_wait", 32'(n), 32'(p));
          period = '0;
          feed(b0, b1, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
          finish_apply(model_seed(b0, b1), 1'b0);
        end
        default: begin
          csr_en = 1'b1;
          csr = $urandom;
          exp_q.push_back(csr);
          smp();
          chkb("idle_csr_strobe", seed_en, 1'b1);
          nxt();
          csr_en = 1'b0;
          smp();
          chkb("idle_csr_no_fetch", busy, 1'b0);
          nxt();
        end
      endcase
    end

    for (int i = 0; i < 4; i++) nxt();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
